// File: rtl/id_ex_ctrl.sv
// ID-stage decode, load-use/multi-cycle hazard control and the ID/EX control register.
module id_ex_ctrl #(
    parameter int unsigned M_EXT      = 1,
    parameter int unsigned MD_LATENCY = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        id_valid,
    input  logic [31:0] id_inst,
    input  logic        flush,
    output logic        stall_id,
    output logic        ex_valid,
    output logic        ex_regwrite,
    output logic        ex_memwrite,
    output logic        ex_memread,
    output logic        ex_alusrc,
    output logic [4:0]  ex_aluop,
    output logic [5:0]  ex_extop,
    output logic [2:0]  ex_npcop,
    output logic [2:0]  ex_dmtype,
    output logic [1:0]  ex_wdsel,
    output logic        ex_md,
    output logic [2:0]  ex_mdop,
    output logic [4:0]  ex_rd,
    output logic        ex_illegal
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(MD_LATENCY - 1);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_L     = 7'b0000011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MUL  = 7'b0000001;

    localparam logic [4:0] ALU_LUI   = 5'b00001;
    localparam logic [4:0] ALU_AUIPC = 5'b00010;
    localparam logic [4:0] ALU_ADD   = 5'b00011;
    localparam logic [4:0] ALU_SUB   = 5'b00100;
    localparam logic [4:0] ALU_BNE   = 5'b00101;
    localparam logic [4:0] ALU_BLT   = 5'b00110;
    localparam logic [4:0] ALU_BGE   = 5'b00111;
    localparam logic [4:0] ALU_BLTU  = 5'b01000;
    localparam logic [4:0] ALU_BGEU  = 5'b01001;
    localparam logic [4:0] ALU_SLT   = 5'b01010;
    localparam logic [4:0] ALU_SLTU  = 5'b01011;
    localparam logic [4:0] ALU_XOR   = 5'b01100;
    localparam logic [4:0] ALU_OR    = 5'b01101;
    localparam logic [4:0] ALU_AND   = 5'b01110;
    localparam logic [4:0] ALU_SLL   = 5'b01111;
    localparam logic [4:0] ALU_SRL   = 5'b10000;
    localparam logic [4:0] ALU_SRA   = 5'b10001;

    localparam logic [5:0] EXT_SHAMT = 6'b100000;
    localparam logic [5:0] EXT_I     = 6'b010000;
    localparam logic [5:0] EXT_S     = 6'b001000;
    localparam logic [5:0] EXT_B     = 6'b000100;
    localparam logic [5:0] EXT_U     = 6'b000010;
    localparam logic [5:0] EXT_J     = 6'b000001;

    localparam logic [2:0] NPC_BRANCH = 3'b001;
    localparam logic [2:0] NPC_JUMP   = 3'b010;
    localparam logic [2:0] NPC_JALR   = 3'b100;

    localparam logic [2:0] DM_W  = 3'b000;
    localparam logic [2:0] DM_H  = 3'b001;
    localparam logic [2:0] DM_HU = 3'b010;
    localparam logic [2:0] DM_B  = 3'b011;
    localparam logic [2:0] DM_BU = 3'b100;

    localparam logic [1:0] WD_MEM = 2'b01;
    localparam logic [1:0] WD_PC  = 2'b10;

    typedef struct packed {
        logic       valid;
        logic       regwrite;
        logic       memwrite;
        logic       memread;
        logic       alusrc;
        logic [4:0] aluop;
        logic [5:0] extop;
        logic [2:0] npcop;
        logic [2:0] dmtype;
        logic [1:0] wdsel;
        logic       md;
        logic [2:0] mdop;
        logic [4:0] rd;
        logic       illegal;
    } bundle_t;

    typedef enum logic {IDLE, BUSY} state_t;

    logic [6:0] opcode;
    logic [6:0] funct7;
    logic [2:0] funct3;
    logic [4:0] rs1;
    logic [4:0] rs2;

    bundle_t            dec;
    bundle_t            ex_q;
    bundle_t            ex_d;
    logic               bad;
    logic               use_rs1;
    logic               use_rs2;
    logic               lu;
    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;

    assign opcode = id_inst[6:0];
    assign funct3 = id_inst[14:12];
    assign funct7 = id_inst[31:25];
    assign rs1    = id_inst[19:15];
    assign rs2    = id_inst[24:20];

    // Decode the ID instruction into a control bundle and its source-use flags.
    always_comb begin
        dec     = '0;
        bad     = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        case (opcode)
            OP_R: begin
                dec.regwrite = 1'b1;
                use_rs1      = 1'b1;
                use_rs2      = 1'b1;
                if (funct7 == F7_MUL && M_EXT != 0) begin
                    dec.md   = 1'b1;
                    dec.mdop = funct3;
                end else if (funct7 == F7_BASE) begin
                    case (funct3)
                        3'b000:  dec.aluop = ALU_ADD;
                        3'b001:  dec.aluop = ALU_SLL;
                        3'b010:  dec.aluop = ALU_SLT;
                        3'b011:  dec.aluop = ALU_SLTU;
                        3'b100:  dec.aluop = ALU_XOR;
                        3'b101:  dec.aluop = ALU_SRL;
                        3'b110:  dec.aluop = ALU_OR;
                        default: dec.aluop = ALU_AND;
                    endcase
                end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
                    dec.aluop = ALU_SUB;
                end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
                    dec.aluop = ALU_SRA;
                end else begin
                    bad = 1'b1;
                end
            end
            OP_I: begin
                dec.regwrite = 1'b1;
                dec.alusrc   = 1'b1;
                dec.extop    = EXT_I;
                use_rs1      = 1'b1;
                case (funct3)
                    3'b000: dec.aluop = ALU_ADD;
                    3'b010: dec.aluop = ALU_SLT;
                    3'b011: dec.aluop = ALU_SLTU;
                    3'b100: dec.aluop = ALU_XOR;
                    3'b110: dec.aluop = ALU_OR;
                    3'b111: dec.aluop = ALU_AND;
                    3'b001: begin
                        dec.extop = EXT_SHAMT;
                        dec.aluop = ALU_SLL;
                        bad       = (funct7 != F7_BASE);
                    end
                    default: begin
                        dec.extop = EXT_SHAMT;
                        if (funct7 == F7_BASE)     dec.aluop = ALU_SRL;
                        else if (funct7 == F7_ALT) dec.aluop = ALU_SRA;
                        else                       bad = 1'b1;
                    end
                endcase
            end
            OP_L: begin
                dec.regwrite = 1'b1;
                dec.memread  = 1'b1;
                dec.alusrc   = 1'b1;
                dec.aluop    = ALU_ADD;
                dec.extop    = EXT_I;
                dec.wdsel    = WD_MEM;
                use_rs1      = 1'b1;
                case (funct3)
                    3'b000:  dec.dmtype = DM_B;
                    3'b001:  dec.dmtype = DM_H;
                    3'b010:  dec.dmtype = DM_W;
                    3'b100:  dec.dmtype = DM_BU;
                    3'b101:  dec.dmtype = DM_HU;
                    default: bad = 1'b1;
                endcase
            end
            OP_S: begin
                dec.memwrite = 1'b1;
                dec.alusrc   = 1'b1;
                dec.aluop    = ALU_ADD;
                dec.extop    = EXT_S;
                use_rs1      = 1'b1;
                use_rs2      = 1'b1;
                case (funct3)
                    3'b000:  dec.dmtype = DM_B;
                    3'b001:  dec.dmtype = DM_H;
                    3'b010:  dec.dmtype = DM_W;
                    default: bad = 1'b1;
                endcase
            end
            OP_B: begin
                dec.npcop = NPC_BRANCH;
                dec.extop = EXT_B;
                use_rs1   = 1'b1;
                use_rs2   = 1'b1;
                case (funct3)
                    3'b000:  dec.aluop = ALU_SUB;
                    3'b001:  dec.aluop = ALU_BNE;
                    3'b100:  dec.aluop = ALU_BLT;
                    3'b101:  dec.aluop = ALU_BGE;
                    3'b110:  dec.aluop = ALU_BLTU;
                    3'b111:  dec.aluop = ALU_BGEU;
                    default: bad = 1'b1;
                endcase
            end
            OP_JAL: begin
                dec.regwrite = 1'b1;
                dec.npcop    = NPC_JUMP;
                dec.extop    = EXT_J;
                dec.wdsel    = WD_PC;
            end
            OP_JALR: begin
                dec.regwrite = 1'b1;
                dec.npcop    = NPC_JALR;
                dec.alusrc   = 1'b1;
                dec.aluop    = ALU_ADD;
                dec.extop    = EXT_I;
                dec.wdsel    = WD_PC;
                use_rs1      = 1'b1;
                bad          = (funct3 != 3'b000);
            end
            OP_LUI: begin
                dec.regwrite = 1'b1;
                dec.alusrc   = 1'b1;
                dec.aluop    = ALU_LUI;
                dec.extop    = EXT_U;
            end
            OP_AUIPC: begin
                dec.regwrite = 1'b1;
                dec.alusrc   = 1'b1;
                dec.aluop    = ALU_AUIPC;
                dec.extop    = EXT_U;
            end
            default: bad = 1'b1;
        endcase
        if (bad) begin
            dec         = '0;
            dec.illegal = 1'b1;
            use_rs1     = 1'b0;
            use_rs2     = 1'b0;
        end
        dec.valid = 1'b1;
        dec.rd    = dec.regwrite ? id_inst[11:7] : 5'd0;
    end

    // Load in EX whose destination feeds a source of the valid ID instruction.
    assign lu = ex_q.valid & ex_q.memread & (ex_q.rd != 5'd0) & id_valid &
                ((use_rs1 & (rs1 == ex_q.rd)) | (use_rs2 & (rs2 == ex_q.rd)));

    assign stall_id = ~flush & (lu | (state_q == BUSY));

    // Next EX bundle and multi-cycle occupancy state; redirect beats everything.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ex_d    = ex_q;
        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
            ex_d    = '0;
        end else if (state_q == BUSY) begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) state_d = IDLE;
        end else if (lu || !id_valid) begin
            ex_d = '0;
        end else begin
            ex_d = dec;
            if (dec.md && MD_LATENCY > 1) begin
                state_d = BUSY;
                cnt_d   = CNT_RELOAD;
            end
        end
    end

    // ID/EX register and FSM state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ex_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ex_q    <= ex_d;
        end
    end

    assign ex_valid    = ex_q.valid;
    assign ex_regwrite = ex_q.regwrite;
    assign ex_memwrite = ex_q.memwrite;
    assign ex_memread  = ex_q.memread;
    assign ex_alusrc   = ex_q.alusrc;
    assign ex_aluop    = ex_q.aluop;
    assign ex_extop    = ex_q.extop;
    assign ex_npcop    = ex_q.npcop;
    assign ex_dmtype   = ex_q.dmtype;
    assign ex_wdsel    = ex_q.wdsel;
    assign ex_md       = ex_q.md;
    assign ex_mdop     = ex_q.mdop;
    assign ex_rd       = ex_q.rd;
    assign ex_illegal  = ex_q.illegal;

endmodule

// File: tb/tb_id_ex_ctrl.sv
// Scoreboard bench for id_ex_ctrl: three instances (M on/lat 4, M off, M on/lat 1) share stimulus.
module tb_id_ex_ctrl;

    typedef struct packed {
        logic       valid;
        logic       regwrite;
        logic       memwrite;
        logic       memread;
        logic       alusrc;
        logic [4:0] aluop;
        logic [5:0] extop;
        logic [2:0] npcop;
        logic [2:0] dmtype;
        logic [1:0] wdsel;
        logic       md;
        logic [2:0] mdop;
        logic [4:0] rd;
        logic       illegal;
    } bundle_t;

    typedef struct packed {
        logic    st;
        bundle_t ex;
    } exp_t;

    localparam int K_BAD = 0, K_R = 1, K_M = 2, K_I = 3, K_SH = 4, K_L = 5, K_S = 6,
                   K_B = 7, K_JAL = 8, K_JALR = 9, K_LUI = 10, K_AUIPC = 11;

    localparam logic [31:0] ADDI_X1 = 32'h00500093;
    localparam logic [31:0] LW_X5   = 32'h0000A283;
    localparam logic [31:0] ADD_X6  = 32'h00228333;
    localparam logic [31:0] LW_X0   = 32'h0000A003;
    localparam logic [31:0] ADD_X0  = 32'h00200333;
    localparam logic [31:0] MUL_X7  = 32'h022083B3;
    localparam logic [31:0] ADDI_X4 = 32'h00100213;

    logic        clk;
    logic        rstn;
    logic        id_valid;
    logic [31:0] id_inst;
    logic        flush;

    logic        st_mon [3];
    bundle_t     ex_mon [3];

    int unsigned mext_of [3] = '{1, 0, 1};
    int unsigned lat_of  [3] = '{4, 4, 1};

    bundle_t     m_ex   [3];
    int          m_left [3];
    exp_t        exp_q  [3][$];
    logic        last_stall;
    int          errors;
    int          checks;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned GM = (g == 1) ? 0 : 1;
        localparam int unsigned GL = (g == 2) ? 1 : 4;
        logic       st, v, rw, mw, mr, as, md, il;
        logic [4:0] aop, rd;
        logic [5:0] eop;
        logic [2:0] npc, dm, mdop;
        logic [1:0] wd;

        id_ex_ctrl #(.M_EXT(GM), .MD_LATENCY(GL)) u_dut (
            .clk         (clk),
            .rstn        (rstn),
            .id_valid    (id_valid),
            .id_inst     (id_inst),
            .flush       (flush),
            .stall_id    (st),
            .ex_valid    (v),
            .ex_regwrite (rw),
            .ex_memwrite (mw),
            .ex_memread  (mr),
            .ex_alusrc   (as),
            .ex_aluop    (aop),
            .ex_extop    (eop),
            .ex_npcop    (npc),
            .ex_dmtype   (dm),
            .ex_wdsel    (wd),
            .ex_md       (md),
            .ex_mdop     (mdop),
            .ex_rd       (rd),
            .ex_illegal  (il)
        );

        assign st_mon[g] = st;
        assign ex_mon[g] = {v, rw, mw, mr, as, aop, eop, npc, dm, wd, md, mdop, rd, il};
    end

    // Reference decode: instruction-by-instruction pattern table.
    function automatic void ref_decode(input logic [31:0] in, input bit mext,
                                       output bundle_t b, output bit u1, output bit u2);
        int         k;
        logic [4:0] alu;
        logic [2:0] dm;
        k   = K_BAD;
        alu = 5'd0;
        dm  = 3'd0;
        casez (in)
            32'b0000000_?????_?????_000_?????_0110011: begin k = K_R; alu = 5'b00011; end
            32'b0100000_?????_?????_000_?????_0110011: begin k = K_R; alu = 5'b00100; end
            32'b0000000_?????_?????_001_?????_0110011: begin k = K_R; alu = 5'b01111; end
            32'b0000000_?????_?????_010_?????_0110011: begin k = K_R; alu = 5'b01010; end
            32'b0000000_?????_?????_011_?????_0110011: begin k = K_R; alu = 5'b01011; end
            32'b0000000_?????_?????_100_?????_0110011: begin k = K_R; alu = 5'b01100; end
            32'b0000000_?????_?????_101_?????_0110011: begin k = K_R; alu = 5'b10000; end
            32'b0100000_?????_?????_101_?????_0110011: begin k = K_R; alu = 5'b10001; end
            32'b0000000_?????_?????_110_?????_0110011: begin k = K_R; alu = 5'b01101; end
            32'b0000000_?????_?????_111_?????_0110011: begin k = K_R; alu = 5'b01110; end
            32'b0000001_?????_?????_???_?????_0110011: if (mext) k = K_M;
            32'b???????_?????_?????_000_?????_0010011: begin k = K_I; alu = 5'b00011; end
            32'b???????_?????_?????_010_?????_0010011: begin k = K_I; alu = 5'b01010; end
            32'b???????_?????_?????_011_?????_0010011: begin k = K_I; alu = 5'b01011; end
            32'b???????_?????_?????_100_?????_0010011: begin k = K_I; alu = 5'b01100; end
            32'b???????_?????_?????_110_?????_0010011: begin k = K_I; alu = 5'b01101; end
            32'b???????_?????_?????_111_?????_0010011: begin k = K_I; alu = 5'b01110; end
            32'b0000000_?????_?????_001_?????_0010011: begin k = K_SH; alu = 5'b01111; end
            32'b0000000_?????_?????_101_?????_0010011: begin k = K_SH; alu = 5'b10000; end
            32'b0100000_?????_?????_101_?????_0010011: begin k = K_SH; alu = 5'b10001; end
            32'b???????_?????_?????_000_?????_0000011: begin k = K_L; dm = 3'b011; end
            32'b???????_?????_?????_001_?????_0000011: begin k = K_L; dm = 3'b001; end
            32'b???????_?????_?????_010_?????_0000011: begin k = K_L; dm = 3'b000; end
            32'b???????_?????_?????_100_?????_0000011: begin k = K_L; dm = 3'b100; end
            32'b???????_?????_?????_101_?????_0000011: begin k = K_L; dm = 3'b010; end
            32'b???????_?????_?????_000_?????_0100011: begin k = K_S; dm = 3'b011; end
            32'b???????_?????_?????_001_?????_0100011: begin k = K_S; dm = 3'b001; end
            32'b???????_?????_?????_010_?????_0100011: begin k = K_S; dm = 3'b000; end
            32'b???????_?????_?????_000_?????_1100011: begin k = K_B; alu = 5'b00100; end
            32'b???????_?????_?????_001_?????_1100011: begin k = K_B; alu = 5'b00101; end
            32'b???????_?????_?????_100_?????_1100011: begin k = K_B; alu = 5'b00110; end
            32'b???????_?????_?????_101_?????_1100011: begin k = K_B; alu = 5'b00111; end
            32'b???????_?????_?????_110_?????_1100011: begin k = K_B; alu = 5'b01000; end
            32'b???????_?????_?????_111_?????_1100011: begin k = K_B; alu = 5'b01001; end
            32'b???????_?????_?????_???_?????_1101111: k = K_JAL;
            32'b???????_?????_?????_000_?????_1100111: k = K_JALR;
            32'b???????_?????_?????_???_?????_0110111: k = K_LUI;
            32'b???????_?????_?????_???_?????_0010111: k = K_AUIPC;
            default: k = K_BAD;
        endcase
        b  = '0;
        u1 = 1'b0;
        u2 = 1'b0;
        case (k)
            K_R:     begin b.regwrite = 1; b.aluop = alu; u1 = 1; u2 = 1; end
            K_M:     begin b.regwrite = 1; b.md = 1; b.mdop = in[14:12]; u1 = 1; u2 = 1; end
            K_I:     begin b.regwrite = 1; b.alusrc = 1; b.aluop = alu; b.extop = 6'b010000; u1 = 1; end
            K_SH:    begin b.regwrite = 1; b.alusrc = 1; b.aluop = alu; b.extop = 6'b100000; u1 = 1; end
            K_L:     begin b.regwrite = 1; b.memread = 1; b.alusrc = 1; b.aluop = 5'b00011;
                           b.extop = 6'b010000; b.dmtype = dm; b.wdsel = 2'b01; u1 = 1; end
            K_S:     begin b.memwrite = 1; b.alusrc = 1; b.aluop = 5'b00011; b.extop = 6'b001000;
                           b.dmtype = dm; u1 = 1; u2 = 1; end
            K_B:     begin b.aluop = alu; b.extop = 6'b000100; b.npcop = 3'b001; u1 = 1; u2 = 1; end
            K_JAL:   begin b.regwrite = 1; b.npcop = 3'b010; b.extop = 6'b000001; b.wdsel = 2'b10; end
            K_JALR:  begin b.regwrite = 1; b.npcop = 3'b100; b.alusrc = 1; b.aluop = 5'b00011;
                           b.extop = 6'b010000; b.wdsel = 2'b10; u1 = 1; end
            K_LUI:   begin b.regwrite = 1; b.alusrc = 1; b.aluop = 5'b00001; b.extop = 6'b000010; end
            K_AUIPC: begin b.regwrite = 1; b.alusrc = 1; b.aluop = 5'b00010; b.extop = 6'b000010; end
            default: b.illegal = 1;
        endcase
        b.valid = 1'b1;
        if (b.regwrite) b.rd = in[11:7];
    endfunction

    // Random instruction biased toward x0..x3 so hazards are frequent.
    function automatic logic [31:0] rand_inst();
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [11:0] imm;
        rd  = 5'($urandom_range(0, 3));
        rs1 = 5'($urandom_range(0, 3));
        rs2 = 5'($urandom_range(0, 3));
        f3  = 3'($urandom_range(0, 7));
        imm = 12'($urandom_range(0, 31));
        case ($urandom_range(0, 3))
            0:       f7 = 7'h00;
            1:       f7 = 7'h20;
            2:       f7 = 7'h01;
            default: f7 = 7'h13;
        endcase
        case ($urandom_range(0, 11))
            0:  return {f7, rs2, rs1, f3, rd, 7'b0110011};
            1:  return {f7, rs2, rs1, f3, rd, 7'b0010011};
            3:  return {f7, rs2, rs1, f3, rd, 7'b0100011};
            4:  return {f7, rs2, rs1, f3, rd, 7'b1100011};
            5:  return {f7, rs2, rs1, f3, rd, 7'b1101111};
            6:  return {imm, rs1, ($urandom_range(0, 1) != 0) ? 3'b000 : f3, rd, 7'b1100111};
            7:  return {f7, rs2, rs1, f3, rd, 7'b0110111};
            8:  return {f7, rs2, rs1, f3, rd, 7'b0010111};
            9:  return {7'h01, rs2, rs1, f3, rd, 7'b0110011};
            10: return 32'($urandom);
            default: return {imm, rs1, f3, rd, 7'b0000011};
        endcase
    endfunction

    // Apply one cycle of inputs after the edge; queue what each DUT must show this cycle.
    task automatic drive(input logic r, input logic v, input logic [31:0] inst, input logic fl);
        bundle_t d;
        bit      u1, u2, lu, st;
        exp_t    e;
        @(posedge clk);
        #1;
        rstn     = r;
        id_valid = v;
        id_inst  = inst;
        flush    = fl;
        for (int i = 0; i < 3; i++) begin
            if (!r) begin
                m_ex[i]   = '0;
                m_left[i] = 0;
            end
            ref_decode(inst, mext_of[i] != 0, d, u1, u2);
            lu = m_ex[i].valid && m_ex[i].memread && (m_ex[i].rd != 5'd0) && v &&
                 ((u1 && inst[19:15] == m_ex[i].rd) || (u2 && inst[24:20] == m_ex[i].rd));
            st = !fl && (lu || m_left[i] > 0);
            e.st = st;
            e.ex = m_ex[i];
            exp_q[i].push_back(e);
            if (i == 0) last_stall = st;
            if (r) begin
                if (fl) begin
                    m_ex[i]   = '0;
                    m_left[i] = 0;
                end else if (m_left[i] > 0) begin
                    m_left[i]--;
                end else if (lu || !v) begin
                    m_ex[i] = '0;
                end else begin
                    m_ex[i] = d;
                    if (d.md) m_left[i] = int'(lat_of[i]) - 1;
                end
            end
        end
    endtask

    // Monitor: every cycle each DUT presents stall_id and an EX bundle; compare with the queue head.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (exp_q[i].size() != 0) begin
                    e = exp_q[i].pop_front();
                    checks++;
                    if (st_mon[i] !== e.st) begin
                        errors++;
                        $display("FAIL stall_id dut%0d t=%0t got=%b exp=%b", i, $time, st_mon[i], e.st);
                    end
                    checks++;
                    if (ex_mon[i] !== e.ex) begin
                        errors++;
                        $display("FAIL ex_bundle dut%0d t=%0t got=%h exp=%h", i, $time, ex_mon[i], e.ex);
                    end
                end
            end
        end
    end

    initial begin : stimulus
        logic [31:0] cur;
        logic        cv;
        errors     = 0;
        checks     = 0;
        last_stall = 1'b0;
        rstn       = 1'b0;
        id_valid   = 1'b0;
        id_inst    = '0;
        flush      = 1'b0;
        for (int i = 0; i < 3; i++) begin
            m_ex[i]   = '0;
            m_left[i] = 0;
        end

        for (int k = 0; k < 3; k++) drive(1'b0, 1'b1, 32'($urandom), 1'b0);
        drive(1'b1, 1'b1, ADDI_X1, 1'b0);
        drive(1'b1, 1'b0, 32'h0, 1'b0);

        drive(1'b1, 1'b1, LW_X5, 1'b0);
        drive(1'b1, 1'b1, ADD_X6, 1'b0);
        drive(1'b1, 1'b1, ADD_X6, 1'b0);
        drive(1'b1, 1'b0, 32'h0, 1'b0);

        drive(1'b1, 1'b1, LW_X0, 1'b0);
        drive(1'b1, 1'b1, ADD_X0, 1'b0);
        drive(1'b1, 1'b0, 32'h0, 1'b0);

        drive(1'b1, 1'b1, MUL_X7, 1'b0);
        repeat (4) drive(1'b1, 1'b1, ADDI_X4, 1'b0);
        drive(1'b1, 1'b0, 32'h0, 1'b0);

        drive(1'b1, 1'b1, MUL_X7, 1'b0);
        repeat (4) drive(1'b1, 1'b1, MUL_X7, 1'b0);
        repeat (4) drive(1'b1, 1'b1, ADDI_X4, 1'b0);
        repeat (2) drive(1'b1, 1'b0, 32'h0, 1'b0);

        drive(1'b1, 1'b1, LW_X5, 1'b0);
        drive(1'b1, 1'b1, ADD_X6, 1'b1);
        drive(1'b1, 1'b0, 32'h0, 1'b0);

        drive(1'b1, 1'b1, MUL_X7, 1'b0);
        drive(1'b1, 1'b1, ADDI_X4, 1'b0);
        drive(1'b1, 1'b1, ADDI_X4, 1'b1);
        repeat (2) drive(1'b1, 1'b0, 32'h0, 1'b0);

        drive(1'b1, 1'b1, MUL_X7, 1'b0);
        drive(1'b1, 1'b1, ADDI_X4, 1'b0);
        drive(1'b0, 1'b1, ADDI_X4, 1'b0);
        drive(1'b1, 1'b1, MUL_X7, 1'b0);
        repeat (4) drive(1'b1, 1'b1, ADDI_X4, 1'b0);
        repeat (2) drive(1'b1, 1'b0, 32'h0, 1'b0);

        cur = 32'h0;
        cv  = 1'b0;
        for (int n = 0; n < 600; n++) begin
            if (!last_stall) begin
                cur = rand_inst();
                cv  = ($urandom_range(0, 7) != 0);
            end
            drive(($urandom_range(0, 149) != 0), cv, cur, ($urandom_range(0, 9) == 0));
        end

        repeat (3) @(negedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (exp_q[i].size() != 0) begin
                errors++;
                $display("FAIL drain dut%0d got=%0d pending exp=0", i, exp_q[i].size());
            end
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
